// File: rtl/slot_alloc.sv
// Slot allocator: MSB-first grant from a free bitmap,
// with release, error pulse on double free, and flush.
module slot_alloc #(
    parameter int WIDTH = 32,
    localparam int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_ack,
    output logic [IDX_WIDTH-1:0] alloc_id,
    input  logic                 free_vld,
    input  logic [IDX_WIDTH-1:0] free_id,
    output logic                 free_err,
    input  logic                 flush,
    output logic [WIDTH-1:0]     busy_map,
    output logic [IDX_WIDTH:0]   free_cnt,
    output logic                 full,
    output logic                 empty
);

    localparam logic [IDX_WIDTH:0] CNT_MAX = (IDX_WIDTH+1)'(WIDTH);

    logic [WIDTH-1:0]     fmap;
    logic [WIDTH-1:0]     fmap_nxt;
    logic [IDX_WIDTH-1:0] cand;
    logic                 grant;
    logic                 rel_ok;
    logic                 rel_bad;

    // Later (higher) set bits overwrite earlier ones: MSB wins.
    always_comb begin
        cand = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (fmap[i]) cand = IDX_WIDTH'(i);
        end
    end

    assign grant   = alloc_req & (|fmap);
    assign rel_ok  = free_vld & ~fmap[free_id];
    assign rel_bad = free_vld & fmap[free_id];

    // Both decisions use the pre-edge map, so a freed
    // slot can never be granted in the same cycle.
    always_comb begin
        fmap_nxt = fmap;
        if (grant) fmap_nxt[cand] = 1'b0;
        if (rel_ok) fmap_nxt[free_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fmap      <= '1;
            busy_map  <= '0;
            free_cnt  <= CNT_MAX;
            alloc_ack <= 1'b0;
            alloc_id  <= '0;
            free_err  <= 1'b0;
        end else if (flush) begin
            fmap      <= '1;
            busy_map  <= '0;
            free_cnt  <= CNT_MAX;
            alloc_ack <= 1'b0;
            free_err  <= 1'b0;
        end else begin
            fmap      <= fmap_nxt;
            busy_map  <= ~fmap_nxt;
            alloc_ack <= grant;
            free_err  <= rel_bad;
            if (grant) alloc_id <= cand;
            unique case ({grant, rel_ok})
                2'b10:   free_cnt <= free_cnt - 1'b1;
                2'b01:   free_cnt <= free_cnt + 1'b1;
                default: free_cnt <= free_cnt;
            endcase
        end
    end

    assign full  = (free_cnt == '0);
    assign empty = (free_cnt == CNT_MAX);

endmodule

// File: tb/tb_slot_alloc.sv
// Scoreboard bench for slot_alloc (WIDTH=8): expected grants
// and error pulses are queued, a monitor pops and compares.
module tb_slot_alloc;

    localparam int W = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req = 1'b0;
    logic          alloc_ack;
    logic [IW-1:0] alloc_id;
    logic          free_vld = 1'b0;
    logic [IW-1:0] free_id = '0;
    logic          free_err;
    logic          flush = 1'b0;
    logic [W-1:0]  busy_map;
    logic [IW:0]   free_cnt;
    logic          full;
    logic          empty;

    int errors = 0;
    int checks = 0;

    int ack_q[$];
    int err_q[$];

    slot_alloc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_ack(alloc_ack),
        .alloc_id(alloc_id), .free_vld(free_vld),
        .free_id(free_id), .free_err(free_err),
        .flush(flush), .busy_map(busy_map),
        .free_cnt(free_cnt), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act,
                       input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_busy"}, int'(busy_map), 0);
        chk({nm, "_cnt"}, int'(free_cnt), 8);
        chk({nm, "_full"}, int'(full), 0);
        chk({nm, "_empty"}, int'(empty), 1);
        chk({nm, "_ack"}, int'(alloc_ack), 0);
        chk({nm, "_id"}, int'(alloc_id), 0);
        chk({nm, "_err"}, int'(free_err), 0);
    endtask

    // Monitor: every ack / err pulse must match a queued entry.
    always @(negedge clk) begin
        if (alloc_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", int'(alloc_id), -1);
            end else begin
                chk("ack_id", int'(alloc_id), ack_q.pop_front());
            end
        end
        if (free_err) begin
            if (err_q.size() == 0) begin
                chk("unexpected_err", 1, 0);
            end else begin
                chk("err_pulse", 1, err_q.pop_front());
            end
        end
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        chk_reset("reset");

        // three back-to-back grants: 7,6,5
        alloc_req = 1'b1;
        ack_q.push_back(7);
        step();
        ack_q.push_back(6);
        step();
        ack_q.push_back(5);
        step();
        alloc_req = 1'b0;
        chk("t1_busy", int'(busy_map), 'hE0);
        chk("t1_cnt", int'(free_cnt), 5);

        // fill up
        alloc_req = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            ack_q.push_back(i);
            step();
        end
        chk("t2_full", int'(full), 1);
        chk("t2_cnt", int'(free_cnt), 0);
        step();
        step();
        chk("t2_hold_id", int'(alloc_id), 0);
        // release 3 while request still held: no bypass
        free_vld = 1'b1;
        free_id = 3'd3;
        step();
        free_vld = 1'b0;
        chk("t2_busy_f7", int'(busy_map), 'hF7);
        chk("t2_noack", int'(alloc_ack), 0);
        ack_q.push_back(3);
        step();
        alloc_req = 1'b0;
        chk("t2_busy_ff", int'(busy_map), 'hFF);
        step();

        // double free after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        free_vld = 1'b1;
        free_id = 3'd7;
        err_q.push_back(1);
        step();
        free_vld = 1'b0;
        chk("t3_busy", int'(busy_map), 0);
        chk("t3_cnt", int'(free_cnt), 8);
        step();
        chk("t3_err_low", int'(free_err), 0);

        // simultaneous grant and release
        alloc_req = 1'b1;
        ack_q.push_back(7);
        step();
        ack_q.push_back(6);
        step();
        free_vld = 1'b1;
        free_id = 3'd7;
        ack_q.push_back(5);
        step();
        free_vld = 1'b0;
        chk("t4_busy", int'(busy_map), 'h60);
        chk("t4_cnt", int'(free_cnt), 6);

        // refill then flush with request
        foreach (ack_q[i]) ;
        ack_q.push_back(7);
        step();
        for (int i = 4; i >= 0; i--) begin
            ack_q.push_back(i);
            step();
        end
        chk("t5_busy_ff", int'(busy_map), 'hFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_busy", int'(busy_map), 0);
        chk("t5_cnt", int'(free_cnt), 8);
        chk("t5_noack", int'(alloc_ack), 0);
        ack_q.push_back(7);
        step();

        // reset during back-to-back grants
        ack_q.push_back(6);
        step();
        ack_q.push_back(5);
        step();
        rst = 1'b1;
        step();
        chk_reset("t6");
        rst = 1'b0;
        alloc_req = 1'b0;
        step();
        chk("t6_noack", int'(alloc_ack), 0);
        step();

        chk("ack_q_drained", ack_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: no finish");
        $fatal(1);
    end

endmodule
